// File: rtl/gray_seq_pkg.sv
// Shared types and helpers for the gray-code sequence scheduler.
// Optional abort feature is enabled with GRAY_SEQ_ABORT_EN (see gray_seq_sched).
package gray_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int count_w(input int size);
    return (size > 2) ? $clog2(size) : 1;
  endfunction

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/gray_step.sv
// Modulo-SIZE binary counter with synchronous clear and step enable.
// Registered gray output presents the code of the value just loaded.
module gray_step import gray_seq_pkg::*; #(
  parameter int SIZE = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clr,
  input  logic                    step,
  output logic [$clog2(SIZE)-1:0] gray
);

  localparam int CW = count_w(SIZE);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] gray_q, gray_d;

  // SIZE is a power of two, so the natural CW-bit wrap is the modulus.
  always_comb begin
    cnt_d  = cnt_q;
    gray_d = gray_q;
    if (clr) begin
      cnt_d = '0;
    end else if (step) begin
      cnt_d = cnt_q + 1'b1;
    end
    if (clr || step) begin
      gray_d = CW'(bin2gray(32'(cnt_d)));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      gray_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      gray_q <= gray_d;
    end
  end

  assign gray = gray_q;

endmodule

// File: rtl/gray_seq_sched.sv
// Round-robin scheduler sharing one gray-code stepper among NREQ requesters.
// Define GRAY_SEQ_ABORT_EN to add the abort input and aborted status output.
module gray_seq_sched import gray_seq_pkg::*; #(
  parameter int NREQ  = 4,
  parameter int SIZE  = 16,
  parameter int LEN_W = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*LEN_W-1:0]   len,
  output logic [NREQ-1:0]         gnt,
  output logic                    busy,
  output logic [$clog2(SIZE)-1:0] gray,
  output logic                    gray_vld,
  output logic                    done,
  output logic [$clog2(NREQ)-1:0] done_id
`ifdef GRAY_SEQ_ABORT_EN
  ,
  input  logic                    abort,
  output logic                    aborted
`endif
);

  localparam int ID_W = $clog2(NREQ);

  state_e            state_q, state_d;
  logic [ID_W-1:0]   rr_q, rr_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [ID_W-1:0]   done_id_q, done_id_d;
  logic [LEN_W-1:0]  left_q, left_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic              busy_q, busy_d;
  logic              vld_q, vld_d;
  logic              done_q, done_d;
  logic              cnt_clr, cnt_step, abort_i;
  logic              found;
  logic [ID_W-1:0]   sel_id;
  logic [ID_W:0]     sum;
  logic [LEN_W-1:0]  len_arr [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_len
    assign len_arr[gi] = len[gi*LEN_W +: LEN_W];
  end

  // Descending scan so the lowest offset from rr_q is the last one kept.
  always_comb begin
    found  = 1'b0;
    sel_id = '0;
    sum    = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      sum = {1'b0, rr_q} + (ID_W+1)'(i);
      if (sum >= (ID_W+1)'(NREQ)) begin
        sum = sum - (ID_W+1)'(NREQ);
      end
      if (req[sum[ID_W-1:0]]) begin
        found  = 1'b1;
        sel_id = sum[ID_W-1:0];
      end
    end
  end

`ifdef GRAY_SEQ_ABORT_EN
  logic aborted_q, aborted_d;
  assign abort_i = abort;
  assign aborted = aborted_q;
`else
  assign abort_i = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    id_d      = id_q;
    left_d    = left_q;
    gnt_d     = '0;
    vld_d     = 1'b0;
    done_d    = 1'b0;
    done_id_d = '0;
    cnt_clr   = 1'b0;
    cnt_step  = 1'b0;
`ifdef GRAY_SEQ_ABORT_EN
    aborted_d = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (found) begin
          id_d  = sel_id;
          rr_d  = (sel_id == ID_W'(NREQ - 1)) ? '0 : sel_id + 1'b1;
          gnt_d = NREQ'(1) << sel_id;
          if (len_arr[sel_id] != '0) begin
            state_d = RUN;
            left_d  = len_arr[sel_id] - 1'b1;
            cnt_clr = 1'b1;
            vld_d   = 1'b1;
          end else begin
            state_d   = DONE;
            done_d    = 1'b1;
            done_id_d = sel_id;
          end
        end
      end
      RUN: begin
        // left_q counts steps still to come after the one on the bus now.
        if (left_q == '0 || abort_i) begin
          state_d   = DONE;
          done_d    = 1'b1;
          done_id_d = id_q;
`ifdef GRAY_SEQ_ABORT_EN
          aborted_d = abort_i;
`endif
        end else begin
          cnt_step = 1'b1;
          left_d   = left_q - 1'b1;
          vld_d    = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      rr_q      <= '0;
      id_q      <= '0;
      left_q    <= '0;
      gnt_q     <= '0;
      busy_q    <= 1'b0;
      vld_q     <= 1'b0;
      done_q    <= 1'b0;
      done_id_q <= '0;
`ifdef GRAY_SEQ_ABORT_EN
      aborted_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      id_q      <= id_d;
      left_q    <= left_d;
      gnt_q     <= gnt_d;
      busy_q    <= busy_d;
      vld_q     <= vld_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
`ifdef GRAY_SEQ_ABORT_EN
      aborted_q <= aborted_d;
`endif
    end
  end

  gray_step #(.SIZE(SIZE)) u_step (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .step  (cnt_step),
    .gray  (gray)
  );

  assign gnt      = gnt_q;
  assign busy     = busy_q;
  assign gray_vld = vld_q;
  assign done     = done_q;
  assign done_id  = done_id_q;

endmodule

// File: doc/gray_seq_sched.md
# gray_seq_sched

Round-robin scheduler that shares one gray-code sequence generator among NREQ requesters. Each requester asks for a run of `len` consecutive gray codes. The block arbitrates, clears and steps an internal gray counter for exactly that many cycles, then reports completion. It sits between the requesting engines and any logic consuming the shared gray-coded index stream.

## Interface

Parameters:
- `NREQ`, 4, number of requesters (2..16)
- `SIZE`, 16, counter modulus; power of two, ≥2
- `LEN_W`, 8, width of each run-length field

Ports:
- `clk`  in  1  clock
- `reset`  in  1  reset, asynchronous, active-high
- `req`  in  NREQ  request bit per requester, level
- `len`  in  NREQ*LEN_W  run length per requester; slice i = `len[i*LEN_W +: LEN_W]`
- `gnt`  out  NREQ  one-hot grant pulse
- `busy`  out  1  high whenever state ≠ IDLE
- `gray`  out  $clog2(SIZE)  current gray code
- `gray_vld`  out  1  `gray` carries a valid step this cycle
- `done`  out  1  one-cycle completion pulse
- `done_id`  out  $clog2(NREQ)  index of the completed requester, valid with `done`
- `abort`  in  1  terminate the current run (only with GRAY_SEQ_ABORT_EN)
- `aborted`  out  1  with `done`: run ended by abort (only with GRAY_SEQ_ABORT_EN)

## Operation

- Reset values: state IDLE, rr pointer 0, all outputs 0, internal binary count 0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - If any `req` bit is set, select the first set bit searching upward, wrapping, from the rr pointer.
  - Latch its id and `len` slice. Set rr pointer to id+1 mod NREQ.
  - If len > 0: clear the count to 0 and go to RUN.
  - If len = 0: go to DONE.
  - With no request, stay in IDLE.
- RUN:
  - One step per cycle. In the k-th RUN cycle (k = 0..len-1): `gray_vld`=1, `gray` = b ^ (b>>1), where b = k mod SIZE.
  - The count wraps from SIZE-1 to 0 and the run continues.
  - After the len-th step, go to DONE.
- DONE: one cycle. `done`=1, `done_id`=latched id. Then go to IDLE.
- `gnt[id]` pulses for one cycle:
  - in the first RUN cycle, or
  - in the DONE cycle when len = 0.
- `req` and `len` are sampled only in IDLE. Changes during RUN or DONE are ignored.
- A requester that keeps `req` high is re-arbitrated. Round robin guarantees every requester is served within NREQ jobs.
- `gray` holds the last emitted code when `gray_vld`=0.
- Reset asserted mid-run:
  - Immediate return to IDLE.
  - No `done` pulse.
  - rr pointer returns to 0.

## Timing

- All outputs are registered.
- Request sampled at edge E; the first valid code is visible in the cycle after E, together with `gnt`.
- A job of len L occupies L+1 cycles after the grant edge: L RUN cycles plus 1 DONE cycle. The next arbitration occurs in the following IDLE cycle.
- Back-to-back throughput: L+2 cycles per job. A len-0 job takes 2 cycles.
- Consecutive valid codes differ in exactly one bit, including across the SIZE-1 → 0 wrap.

## Configuration

- With `GRAY_SEQ_ABORT_EN` defined:
  - The `abort` and `aborted` ports exist.
  - `abort`=1 sampled in a RUN cycle ends the run: that cycle's step is the last one emitted, and DONE follows with `aborted`=1.
  - `abort` has no effect in IDLE or DONE.
  - `aborted` is 0 on a normal completion.
- Without the macro: both ports are absent and every run completes its full length.

## Structure

- Package `gray_seq_pkg` holds:
  - the state enum (IDLE, RUN, DONE);
  - function `bin2gray`;
  - the localparam computation for the count width.
- Sub-module `gray_step`: binary counter modulo SIZE with synchronous clear and step enable, plus registered gray output. The scheduler instantiates one.

## Test plan

- Single request, req=0001, len[0]=5, SIZE=16 → `gnt`=0001 for 1 cycle; gray sequence 0,1,3,2,6 with `gray_vld`=1 for 5 cycles; `done`=1 with `done_id`=0 in the next cycle.
- len=20, SIZE=16 → codes 0..15 mapped as 0,1,3,2,…,8, then 0,1,3,2; the wrap changes one bit; `done` after 20 steps.
- All four requesters hold req=1111, len=2 each → grants in order 0,1,2,3,0; each job 4 cycles apart.
- len=0 on requester 2 → `gnt`=0100 and `done`=1 with `done_id`=2 in the same cycle; `gray_vld` never asserts.
- Reset asserted on the 3rd RUN cycle of a len=10 run → all outputs 0 next cycle; no `done`; the next grant goes to the lowest set req bit.
- GRAY_SEQ_ABORT_EN, len=10, abort on the 4th step → exactly 4 valid codes, then `done`=1 with `aborted`=1.
